// File: rtl/backprop_stack_pipe_pkg.sv
// gdo: fixed-point format, saturating arithmetic and shared enums for backprop_stack_pipe.
package gdo;
    localparam int gdo_size = 8;

    typedef enum logic [1:0] {OP_ACCUM, OP_CLEAR, OP_PROP, OP_READ} op_t;
    typedef enum logic [1:0] {S_IDLE, S_PROP, S_DOT, S_OUT} state_t;

    function automatic logic signed [63:0] gdo_sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return x > hi ? hi : x < -hi - 64'sd1 ? -hi - 64'sd1 : x;
    endfunction

    function automatic logic signed [63:0] gdo_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return gdo_sat(a + b, w);
    endfunction

    function automatic logic signed [63:0] gdo_mult(input logic signed [63:0] a, input logic signed [63:0] b, input int w, input int f);
        return gdo_sat((a * b) >>> f, w);
    endfunction
endpackage

// File: rtl/backprop_stack_pipe_mac.sv
// backprop_mac: one saturating multiply-accumulate step per enabled cycle.
// sum is the result of the current step; clear restarts the chain from zero.
module backprop_mac import gdo::*; #(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = gdo_size
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clear,
    input  logic signed [DATA_SIZE-1:0] a,
    input  logic signed [DATA_SIZE-1:0] b,
    output logic signed [DATA_SIZE-1:0] sum
);
    logic signed [DATA_SIZE-1:0] acc;
    logic signed [63:0] prod;

    always_comb begin
        prod = gdo_mult(64'(a), 64'(b), DATA_SIZE, FRAC_BITS);
        sum = DATA_SIZE'(gdo_add(clear ? 64'sd0 : 64'(acc), prod, DATA_SIZE));
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) acc <= '0;
        else if (en) acc <= sum;
endmodule

// File: rtl/backprop_stack_pipe.sv
// backprop_stack_pipe: per-layer gradient storage with propagate (matrix product) and
// read (row dot product) commands, both executed one MAC per cycle on a shared MAC.
module backprop_stack_pipe import gdo::*; #(
    parameter int DATA_SIZE  = 16,
    parameter int SIZE       = 3,
    parameter int MAX_LAYERS = 4,
    parameter int FRAC_BITS  = gdo_size
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     op,
    input  logic [$clog2(MAX_LAYERS):0]    layer_idx,
    input  logic [DATA_SIZE*SIZE-1:0]      backprop_start,
    input  logic [DATA_SIZE*SIZE-1:0]      backprop_to_all,
    input  logic [DATA_SIZE*SIZE-1:0]      backprop_dense,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_SIZE*SIZE-1:0]      dc_dw_stream,
    output logic                           busy,
    output logic                           error
);
    localparam int AW = $clog2(MAX_LAYERS);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(SIZE);

    typedef logic signed [DATA_SIZE-1:0] word_t;

    word_t dw [MAX_LAYERS][SIZE][SIZE];
    word_t old [MAX_LAYERS][SIZE][SIZE];
    word_t dense [SIZE][SIZE];
    word_t buff [SIZE][SIZE];
    word_t st [SIZE];
    word_t ta [SIZE];
    word_t de [SIZE];
    word_t mac_a, mac_b, mac_sum;

    state_t state, state_nx;
    logic [AW-1:0] tl, lyr, la;
    logic [IW-1:0] kc, jc, ic;
    logic illegal, accum_cmd, clear_cmd, last_k, last_el, prop_end, mac_en;

    always_comb begin
        for (int x = 0; x < SIZE; x++) begin
            st[x] = backprop_start[(SIZE-x)*DATA_SIZE-1 -: DATA_SIZE];
            ta[x] = backprop_to_all[(SIZE-x)*DATA_SIZE-1 -: DATA_SIZE];
            de[x] = backprop_dense[(SIZE-x)*DATA_SIZE-1 -: DATA_SIZE];
        end
    end

    assign la = layer_idx[AW-1:0];
    assign illegal = layer_idx >= LW'(MAX_LAYERS) || (op == OP_READ && layer_idx == LW'(MAX_LAYERS - 1));
    assign accum_cmd = in_valid && !illegal && op == OP_ACCUM;
    assign clear_cmd = in_valid && !illegal && op == OP_CLEAR;
    // PROP walks (layer, r=ic, c=jc, k=kc); DOT walks (r=ic, c=kc) with jc held at 0
    assign last_k = kc == IW'(SIZE - 1);
    assign last_el = last_k && ic == IW'(SIZE - 1) && (state == S_DOT || jc == IW'(SIZE - 1));
    assign prop_end = tl == '0 || (last_el && lyr == tl - 1'b1);
    assign mac_en = state == S_PROP || state == S_DOT;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy = 1'b1;
        out_valid = 1'b0;
        mac_a = old[lyr][kc][ic];
        mac_b = dense[jc][kc];
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy = 1'b0;
                if (in_valid && !illegal && op == OP_PROP) state_nx = S_PROP;
                else if (in_valid && !illegal && op == OP_READ) state_nx = S_DOT;
            end
            S_PROP: state_nx = prop_end ? S_IDLE : S_PROP;
            S_DOT: begin
                mac_a = dw[tl][kc][ic];
                mac_b = old[tl + 1'b1][ic][kc];
                if (last_el) state_nx = S_OUT;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= state_nx;

    backprop_mac #(.DATA_SIZE(DATA_SIZE), .FRAC_BITS(FRAC_BITS)) u_mac (
        .clk(clk),
        .reset(reset),
        .en(mac_en),
        .clear(kc == '0),
        .a(mac_a),
        .b(mac_b),
        .sum(mac_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < MAX_LAYERS; l++)
                for (int c = 0; c < SIZE; c++)
                    for (int r = 0; r < SIZE; r++) begin
                        dw[l][c][r] <= '0;
                        old[l][c][r] <= '0;
                    end
            for (int c = 0; c < SIZE; c++)
                for (int r = 0; r < SIZE; r++) begin
                    dense[c][r] <= '0;
                    buff[c][r] <= '0;
                end
            {tl, lyr, kc, jc, ic} <= '0;
            error <= 1'b0;
            dc_dw_stream <= '0;
        end else begin
            error <= in_valid && state == S_IDLE && illegal;
            if (state == S_IDLE) begin
                tl <= la;
                {lyr, kc, jc, ic} <= '0;
                for (int c = 0; c < SIZE; c++) begin
                    for (int r = 0; r < SIZE; r++) begin
                        if (accum_cmd) dw[la][c][r] <= DATA_SIZE'(gdo_add(64'(dw[la][c][r]), 64'(st[r]), DATA_SIZE));
                        if (clear_cmd) begin
                            dw[la][c][r] <= '0;
                            old[la][c][r] <= '0;
                        end
                    end
                    if (accum_cmd) begin
                        for (int r = 0; r < SIZE - 1; r++) begin
                            old[la][c][r] <= old[la][c][r+1];
                            dense[c][r] <= dense[c][r+1];
                        end
                        old[la][c][SIZE-1] <= ta[c];
                        dense[c][SIZE-1] <= de[c];
                    end
                end
            end else if (mac_en) begin
                if (last_k) begin
                    kc <= '0;
                    buff[jc][ic] <= mac_sum;
                    if (state == S_PROP && jc != IW'(SIZE - 1)) jc <= jc + 1'b1;
                    else begin
                        jc <= '0;
                        ic <= ic == IW'(SIZE - 1) ? '0 : ic + 1'b1;
                        if (ic == IW'(SIZE - 1)) lyr <= lyr + 1'b1;
                    end
                end else kc <= kc + 1'b1;
                // the buffered layer only overwrites the live one once all its products are done
                if (state == S_PROP && tl != '0 && last_el)
                    for (int c = 0; c < SIZE; c++)
                        for (int r = 0; r < SIZE; r++)
                            old[lyr][c][r] <= (c == SIZE - 1 && r == SIZE - 1) ? mac_sum : buff[c][r];
                if (state == S_DOT && last_el)
                    for (int r = 0; r < SIZE; r++)
                        dc_dw_stream[(SIZE-r)*DATA_SIZE-1 -: DATA_SIZE] <= r == SIZE - 1 ? mac_sum : buff[0][r];
            end
        end
    end
endmodule
